// File: rtl/spi_slave_frontend.sv
// SPI mode-0 slave front end: synchronizes the raw pins into the clk domain,
// detects SCLK edges, and shifts receive and transmit words MSB first.
module spi_slave_frontend #(
  parameter int dataWidth  = 8,
  parameter int countWidth = 3
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 sclkIn,
  input  logic                 csIn,
  input  logic                 mosiIn,
  input  logic [dataWidth-1:0] txData,
  output logic                 misoOut,
  output logic                 sclkPosEdge,
  output logic                 sclkNegEdge,
  output logic                 sclk8PosEdge,
  output logic [dataWidth-1:0] rxData,
  output logic                 frameActive,
  output logic                 stateDbg
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [countWidth-1:0] LastBit = countWidth'(dataWidth - 1);

  state_t                 state;
  logic                   sclk_s1, sclk_s2, sclk_s3;
  logic                   cs_s1, cs_s2;
  logic                   mosi_s1, mosi_s2;
  logic                   sclk_rise, sclk_fall;
  logic [countWidth-1:0]  bit_count;
  logic [dataWidth-1:0]   rx_shift;
  logic [dataWidth-1:0]   tx_shift;

  // Chip select resets to its inactive (high) level so no frame starts out of reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclkIn;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= csIn;
      cs_s2   <= cs_s1;
      mosi_s1 <= mosiIn;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;

  // sclk8PosEdge is a valid-only strobe for rxData: there is no ready, the
  // word is held until the next completion and a late consumer simply misses it.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      bit_count    <= '0;
      rx_shift     <= '0;
      rxData       <= '0;
      tx_shift     <= '0;
      misoOut      <= 1'b0;
      sclkPosEdge  <= 1'b0;
      sclkNegEdge  <= 1'b0;
      sclk8PosEdge <= 1'b0;
    end else begin
      sclkPosEdge  <= 1'b0;
      sclkNegEdge  <= 1'b0;
      sclk8PosEdge <= 1'b0;
      case (state)
        IDLE: begin
          misoOut <= 1'b0;
          if (!cs_s2) begin
            state     <= ACTIVE;
            bit_count <= '0;
            tx_shift  <= txData;
          end
        end
        ACTIVE: begin
          // A deasserting chip select outranks any SCLK edge seen in the same cycle.
          if (cs_s2) begin
            state     <= IDLE;
            bit_count <= '0;
            misoOut   <= 1'b0;
          end else begin
            misoOut <= tx_shift[dataWidth-1];
            if (sclk_rise) begin
              sclkPosEdge <= 1'b1;
              rx_shift    <= {rx_shift[dataWidth-2:0], mosi_s2};
              if (bit_count == LastBit) begin
                bit_count    <= '0;
                sclk8PosEdge <= 1'b1;
                rxData       <= {rx_shift[dataWidth-2:0], mosi_s2};
              end else begin
                bit_count <= bit_count + countWidth'(1);
              end
            end
            if (sclk_fall) begin
              sclkNegEdge <= 1'b1;
              // A zero count on a falling edge means a word just finished: fetch the next one.
              if (bit_count == '0) begin
                tx_shift <= txData;
              end else begin
                tx_shift <= {tx_shift[dataWidth-2:0], 1'b0};
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign frameActive = (state == ACTIVE);
  assign stateDbg    = state;

endmodule

// File: doc/spi_slave_frontend.md
SPI_SLAVE_FRONTEND -- requirements
Module: spi_slave_frontend

Interface
REQ-001 Parameter: dataWidth, 8, bits per SPI word; sclk8PosEdge fires once per dataWidth rising SCLK edges.
REQ-002 Parameter: countWidth, 3, width of bit counter; SHALL equal ceil(log2(dataWidth)).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rstN  input  1  asynchronous, active-low reset.
REQ-005 sclkIn  input  1  raw SPI serial clock from pin, asynchronous to clk, idle low (mode 0).
REQ-006 csIn  input  1  raw SPI chip select from pin, active low, asynchronous.
REQ-007 mosiIn  input  1  raw SPI master-out data, asynchronous.
REQ-008 txData  input  dataWidth  next word to transmit; sampled at load events only.
REQ-009 misoOut  output  1  SPI slave-out data, registered.
REQ-010 sclkPosEdge  output  1  one-clk pulse per synchronized SCLK rising edge while frame active.
REQ-011 sclkNegEdge  output  1  one-clk pulse per synchronized SCLK falling edge while frame active.
REQ-012 sclk8PosEdge  output  1  one-clk pulse coincident with sclkPosEdge that completes a word.
REQ-013 rxData  output  dataWidth  last completed received word, MSB first.
REQ-014 frameActive  output  1  high while FSM in ACTIVE.

Function
REQ-015 sclkIn, csIn, mosiIn SHALL each pass a 2-flop synchronizer; edge detection SHALL compare 2nd stage with a 3rd registered copy.
REQ-016 Edge latency: sclkPosEdge/sclkNegEdge SHALL assert in the cycle after the 3rd clk edge sampling the new sclkIn level, for exactly one cycle.
REQ-017 FSM states: IDLE, ACTIVE; IDLE->ACTIVE when synced cs low; ACTIVE->IDLE when synced cs high.
REQ-018 On IDLE->ACTIVE: bitCount <= 0, txShift <= txData.
REQ-019 In IDLE: sclkPosEdge, sclkNegEdge, sclk8PosEdge SHALL be 0; misoOut SHALL be 0; SCLK edges ignored.
REQ-020 On each active rising edge: rxShift <= {rxShift[dataWidth-2:0], synced mosi}; bitCount <= bitCount+1, wrapping dataWidth-1 -> 0.
REQ-021 When rising edge occurs with bitCount == dataWidth-1: sclk8PosEdge pulses same cycle as sclkPosEdge; rxData <= completed word (including current bit) in that same clk edge.
REQ-022 On each active falling edge: if bitCount == 0 (word just completed) txShift <= txData, else txShift shifts left one bit, LSB filled with 0.
REQ-023 misoOut SHALL be txShift MSB, registered, in ACTIVE.
REQ-024 Cs deassert mid-word: partial word discarded, bitCount <= 0, rxData unchanged, no sclk8PosEdge.
REQ-025 Cs deassert sampled in same cycle as a detected SCLK edge: deassert wins; no edge pulse, no shift, no count.
REQ-026 Consecutive words within one frame SHALL be received back-to-back with no dropped bits; rxData holds each word until next completion.
REQ-027 Max SCLK frequency: clk/8; faster SCLK behaviour undefined.

Reset
REQ-028 rstN low SHALL immediately force: FSM IDLE, all synchronizer flops 0 except cs stages 1, bitCount 0, rxShift/rxData/txShift 0, all pulse outputs 0, misoOut 0, frameActive 0.
REQ-029 Reset mid-frame SHALL abandon the word; after release FSM re-enters ACTIVE only after synced cs observed low.

Verification
REQ-030 Reset, cs low, send 0xA5 MSB-first -> 8 sclkPosEdge pulses, one sclk8PosEdge on 8th, rxData = 0xA5.
REQ-031 txData = 0x3C before cs fall, 8 SCLK cycles -> misoOut sampled at SCLK rising edges = 0,0,1,1,1,1,0,0.
REQ-032 One frame, 3 words 0x01,0xFF,0x80 -> 3 sclk8PosEdge pulses; rxData sequence 0x01,0xFF,0x80; txData changed each word appears on MISO next word.
REQ-033 Cs high after 5 bits -> no sclk8PosEdge, rxData keeps prior value; next frame 0x5A received correctly.
REQ-034 rstN low after 4 bits -> all outputs 0 asynchronously; after release and new frame, 0xC3 received correctly.
REQ-035 Single SCLK rising edge -> sclkPosEdge high exactly one clk cycle, 3 clk edges after pin transition sampled.
